// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath widths, fetch defaults, NOP
// encoding, the in-flight read descriptor and a wrapping PC adder.
package cpu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned     PC_INC_DEFAULT   = 4;

    // addi x0, x0, 0
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    // Descriptor of the single outstanding instruction memory read.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
    } inflight_t;

    // 32-bit PC advance; wraps silently at 2^32.
    function automatic logic [XLEN-1:0] pc_add(input logic [XLEN-1:0] base,
                                               input int unsigned     inc);
        return base + XLEN'(inc);
    endfunction

endpackage

// File: rtl/fetch_hold_reg.sv
// Single-entry {instr, pc} holding register used to park an instruction that
// decode could not take while its memory read data was only valid for one cycle.
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   capture         load d_instr/d_pc and mark the entry valid (wins over clear)
//   clear           invalidate the entry
//   d_instr, d_pc   data to capture
//   valid, instr, pc  registered entry contents
module fetch_hold_reg
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            capture,
    input  logic            clear,
    input  logic [ILEN-1:0] d_instr,
    input  logic [XLEN-1:0] d_pc,
    output logic            valid,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] pc
);

    // Entry storage; payload only changes on capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (capture) begin
            valid <= 1'b1;
            instr <= d_instr;
            pc    <= d_pc;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential or redirected reads to a
// one-cycle-latency instruction memory and presents the returned instruction
// to decode, parking it in a one-entry hold register across decode stalls.
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   stall_in                   decode cannot accept this cycle
//   branch_taken/branch_target redirect fetch to branch_target this cycle
//   flush_in                   kill the instruction presented this cycle
//   imem_en/imem_addr          instruction memory read request (combinational)
//   imem_data                  read data, valid the cycle after imem_en
//   if_valid/if_instr/if_pc    instruction presented to decode
//   fetch_count                instructions accepted by decode since reset
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned PC_INC   = PC_INC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        flush_in,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] fetch_count
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    inflight_t       infl_q;
    inflight_t       infl_d;
    logic [31:0]     count_q;
    logic [31:0]     count_d;

    logic            hold_valid;
    logic [ILEN-1:0] hold_instr;
    logic [XLEN-1:0] hold_pc;
    logic            hold_capture;
    logic            hold_clear;

    logic            live;
    logic [ILEN-1:0] pres_instr;
    logic [XLEN-1:0] pres_pc;
    logic            accept;

    fetch_hold_reg u_hold (
        .clk     (clk),
        .reset   (reset),
        .capture (hold_capture),
        .clear   (hold_clear),
        .d_instr (imem_data),
        .d_pc    (infl_q.pc),
        .valid   (hold_valid),
        .instr   (hold_instr),
        .pc      (hold_pc)
    );

    // Source select, request generation and next-state computation.
    always_comb begin
        pc_d         = pc_q;
        infl_d       = '{valid: 1'b0, pc: infl_q.pc};
        count_d      = count_q;
        hold_capture = 1'b0;
        hold_clear   = 1'b0;
        imem_en      = 1'b0;
        imem_addr    = pc_q;
        live         = 1'b0;
        pres_instr   = '0;
        pres_pc      = '0;

        // A parked instruction is always older than anything in flight.
        if (hold_valid) begin
            live       = 1'b1;
            pres_instr = hold_instr;
            pres_pc    = hold_pc;
        end else if (infl_q.valid) begin
            live       = 1'b1;
            pres_instr = imem_data;
            pres_pc    = infl_q.pc;
        end

        accept = live && !flush_in && !stall_in;

        if (branch_taken) begin
            imem_en    = 1'b1;
            imem_addr  = branch_target;
            pc_d       = pc_add(branch_target, PC_INC);
            infl_d     = '{valid: 1'b1, pc: branch_target};
            hold_clear = 1'b1;
        end else if (stall_in) begin
            // Read data vanishes next cycle, so park it unless it is being killed.
            hold_capture = infl_q.valid && !hold_valid && !flush_in;
            hold_clear   = flush_in;
        end else begin
            imem_en    = 1'b1;
            imem_addr  = pc_q;
            pc_d       = pc_add(pc_q, PC_INC);
            infl_d     = '{valid: 1'b1, pc: pc_q};
            // Whatever was presented is either accepted or flushed this cycle.
            hold_clear = 1'b1;
        end

        if (accept) begin
            count_d = count_q + 32'd1;
        end

        if_valid    = live && !flush_in;
        if_instr    = pres_instr;
        if_pc       = pres_pc;
        fetch_count = count_q;

        // Outputs are quiet for the whole reset cycle, not just after the edge.
        if (reset) begin
            imem_en     = 1'b0;
            if_valid    = 1'b0;
            if_instr    = '0;
            if_pc       = '0;
            fetch_count = '0;
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            infl_q  <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            infl_q  <= infl_d;
            count_q <= count_d;
        end
    end

    // A redirect must always kill the wrong-path instruction in decode.
    assert property (@(posedge clk) disable iff (reset) branch_taken |-> flush_in);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// stall/branch/reset traffic, checked cycle by cycle against an
// instruction-stream reference model. Memory returns addr+1000.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] INC    = 32'd4;

    logic        clk;
    logic        reset;
    logic        stall_in;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        flush_in;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] fetch_count;

    fetch_unit #(.RESET_PC(RST_PC), .PC_INC(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall_in      (stall_in),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .flush_in      (flush_in),
        .imem_en       (imem_en),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .fetch_count   (fetch_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks;
    int n_errors;

    // Reference model: the next address to fetch, the instruction offered to
    // decode next cycle (if any), the accepted count, and last cycle's read.
    logic [31:0] m_npc;
    logic        m_pv;
    logic [31:0] m_ppc;
    logic [31:0] m_cnt;
    logic        m_last_en;
    logic [31:0] m_last_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs at negedge, advance model.
    task automatic cycle(input logic rst, input logic st, input logic br, input logic [31:0] tgt);
        logic        e_en;
        logic [31:0] e_addr;
        logic        e_valid;
        logic        acc;
        reset         = rst;
        stall_in      = st;
        branch_taken  = br;
        flush_in      = br;
        branch_target = tgt;
        imem_data     = m_last_en ? m_last_addr + 32'd1000 : $urandom;
        e_en    = !rst && (br || !st);
        e_addr  = br ? tgt : m_npc;
        e_valid = !rst && m_pv && !br;
        @(negedge clk);
        check("imem_en", 32'(imem_en), 32'(e_en));
        if (e_en) check("imem_addr", imem_addr, e_addr);
        check("if_valid", 32'(if_valid), 32'(e_valid));
        if (rst) begin
            check("if_pc_rst", if_pc, 32'h0);
            check("if_instr_rst", if_instr, 32'h0);
        end else if (e_valid) begin
            check("if_pc", if_pc, m_ppc);
            check("if_instr", if_instr, m_ppc + 32'd1000);
        end
        check("fetch_count", fetch_count, rst ? 32'h0 : m_cnt);
        @(posedge clk);
        if (rst) begin
            m_npc     = RST_PC;
            m_pv      = 1'b0;
            m_cnt     = 32'h0;
            m_last_en = 1'b0;
        end else begin
            acc = m_pv && !br && !st;
            if (acc) m_cnt = m_cnt + 32'd1;
            if (br) begin
                m_pv  = 1'b1;
                m_ppc = tgt;
                m_npc = tgt + INC;
            end else if (st) begin
                m_pv = m_pv && !br;
            end else begin
                m_pv  = 1'b1;
                m_ppc = m_npc;
                m_npc = m_npc + INC;
            end
            m_last_en   = e_en;
            m_last_addr = e_addr;
        end
        #1;
    endtask

    initial begin
        logic        r_rst;
        logic        r_st;
        logic        r_br;
        logic [31:0] r_tgt;
        n_checks      = 0;
        n_errors      = 0;
        m_npc         = RST_PC;
        m_pv          = 1'b0;
        m_ppc         = 32'h0;
        m_cnt         = 32'h0;
        m_last_en     = 1'b0;
        m_last_addr   = 32'h0;
        reset         = 1'b1;
        stall_in      = 1'b0;
        branch_taken  = 1'b0;
        flush_in      = 1'b0;
        branch_target = 32'h0;
        imem_data     = 32'h0;
        @(posedge clk);
        #1;

        // Reset, then sequential fetch of 0, 4, 8.
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        // Stall three cycles while pc 0x8 is presented.
        repeat (3) cycle(1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check("fc_after_3_accepts", fetch_count, 32'd3);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        // Redirect to 0x100 while 0x10 is presented (flushed, not counted).
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0100);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check("fc_after_flush", fetch_count, 32'd5);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        // Branch together with stall, stall held two more cycles.
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_0200);
        repeat (2) cycle(1'b0, 1'b1, 1'b0, 32'h0);
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        // Reset while an instruction is parked in hold.
        repeat (2) cycle(1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (2) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        // PC wrap at the top of the address space.
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            r_rst = ($urandom_range(0, 99) < 2);
            r_br  = ($urandom_range(0, 99) < 15);
            r_st  = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 3) == 0)
                r_tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4;
            else
                r_tgt = $urandom & 32'hFFFF_FFFC;
            cycle(r_rst, r_st, r_br, r_tgt);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
